// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the oversampling UART receive path.
//               Receiver state encoding, parity-type constants and a ceil-log2
//               helper usable in constant expressions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver states
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP1  = 3'd4;
    localparam logic [2:0] c_ST_STOP2  = 3'd5;

    // Parity-type selector values (odd_or_even_parity input)
    localparam logic c_PAR_ODD  = 1'b0;
    localparam logic c_PAR_EVEN = 1'b1;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. The head word is
//               presented on o_rdata whenever o_empty is low; o_rdata reads
//               as zero while empty.
//   clk, rst  : clock, asynchronous active-high reset (flushes the FIFO)
//   i_push    : write i_wdata (accepted when not full, or full with a pop)
//   i_pop     : remove head word (ignored while empty)
//   o_rdata   : head word
//   o_full / o_empty / o_count : occupancy status, o_count = 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [clog2(DEPTH):0] o_count
);

    localparam int              c_AW   = clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    always_comb begin
        w_do_pop  = i_pop && (r_count != '0);
        w_do_push = i_push && ((r_count != c_FULL) || w_do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: its contents are masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Oversampling UART receiver with mid-bit majority vote,
//               false-start rejection, optional parity, 1 or 2 stop bits and
//               a first-word-fall-through receive FIFO carrying per-word
//               framing/parity error flags and a sticky overrun flag.
//   clk, rst            : clock, asynchronous active-high reset
//   rx                  : serial line (idle high, asynchronous)
//   parity_en           : parity bit follows the data bits
//   odd_or_even_parity  : 1 = even, 0 = odd parity
//   two_stop            : check two stop bits
//   rd_en               : pop head word
//   rd_data/rd_ferr/rd_perr : head word and its error flags
//   empty/full/count    : FIFO status
//   overrun             : sticky, a completed frame was dropped
//   busy                : receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int SYS_CLK    = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    input  logic                       parity_en,
    input  logic                       odd_or_even_parity,
    input  logic                       two_stop,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_ferr,
    output logic                       rd_perr,
    output logic                       empty,
    output logic                       full,
    output logic [clog2(FIFO_DEPTH):0] count,
    output logic                       overrun,
    output logic                       busy
);

    localparam int c_DIV_RAW = SYS_CLK / (BAUD_RATE * OVERSAMPLE);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_DIVW    = clog2(c_DIV) + 1;
    localparam int c_SCW     = clog2(OVERSAMPLE);
    localparam int c_BITW    = clog2(DATA_WIDTH);
    localparam int c_FW      = DATA_WIDTH + 2;

    localparam logic [c_DIVW-1:0] c_DIV_LAST = c_DIVW'(c_DIV - 1);
    localparam logic [c_SCW-1:0]  c_SC_V0    = c_SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SCW-1:0]  c_SC_V1    = c_SCW'(OVERSAMPLE / 2);
    localparam logic [c_SCW-1:0]  c_SC_DEC   = c_SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [c_SCW-1:0]  c_SC_LAST  = c_SCW'(OVERSAMPLE - 1);
    localparam logic [c_BITW-1:0] c_BIT_LAST = c_BITW'(DATA_WIDTH - 1);

    // Registers
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [c_DIVW-1:0]     r_div_cnt;
    logic [2:0]            r_state;
    logic [c_SCW-1:0]      r_sc;
    logic [c_BITW-1:0]     r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [1:0]            r_votes;
    logic                  r_par_en;
    logic                  r_par_type;
    logic                  r_two_stop;
    logic                  r_ferr;
    logic                  r_perr;
    logic                  r_overrun;

    // Next-state / combinational
    logic                  w_tick;
    logic                  w_vote;
    logic                  w_at_dec;
    logic                  w_at_end;
    logic                  w_par_expect;
    logic [2:0]            w_state_nxt;
    logic [c_SCW-1:0]      w_sc_nxt;
    logic [c_BITW-1:0]     w_bit_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [1:0]            w_votes_nxt;
    logic                  w_par_en_nxt;
    logic                  w_par_type_nxt;
    logic                  w_two_stop_nxt;
    logic                  w_ferr_nxt;
    logic                  w_perr_nxt;
    logic                  w_push;
    logic [c_FW-1:0]       w_wdata;
    logic [c_FW-1:0]       w_head;
    logic                  w_full;
    logic                  w_empty;

    // Synchroniser, tick divider and receiver state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_div_cnt  <= '0;
            r_state    <= c_ST_IDLE;
            r_sc       <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_votes    <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_two_stop <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_s     <= r_rx_meta;
            r_div_cnt  <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_state    <= w_state_nxt;
            r_sc       <= w_sc_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_votes    <= w_votes_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_type <= w_par_type_nxt;
            r_two_stop <= w_two_stop_nxt;
            r_ferr     <= w_ferr_nxt;
            r_perr     <= w_perr_nxt;
        end
    end

    // Two earlier samples are held in r_votes; the third is the live sample
    // at the decision point.
    always_comb begin
        w_tick       = (r_div_cnt == c_DIV_LAST);
        w_vote       = (r_votes[0] & r_votes[1]) | (r_votes[0] & r_rx_s) |
                       (r_votes[1] & r_rx_s);
        w_at_dec     = w_tick && (r_sc == c_SC_DEC);
        w_at_end     = w_tick && (r_sc == c_SC_LAST);
        w_par_expect = (r_par_type == c_PAR_EVEN) ? 1'b0 : 1'b1;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sc_nxt       = r_sc;
        w_bit_nxt      = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_votes_nxt    = r_votes;
        w_par_en_nxt   = r_par_en;
        w_par_type_nxt = r_par_type;
        w_two_stop_nxt = r_two_stop;
        w_ferr_nxt     = r_ferr;
        w_perr_nxt     = r_perr;
        w_push         = 1'b0;
        // The final stop-bit sample is folded in directly so the word can be
        // written in the same cycle the decision is made.
        w_wdata        = {r_ferr | ~w_vote, r_perr, r_shift};

        if (w_tick && (r_state != c_ST_IDLE)) begin
            w_sc_nxt = (r_sc == c_SC_LAST) ? '0 : r_sc + 1'b1;
            if (r_sc == c_SC_V0) w_votes_nxt[0] = r_rx_s;
            if (r_sc == c_SC_V1) w_votes_nxt[1] = r_rx_s;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (w_tick && !r_rx_s) begin
                    w_state_nxt = c_ST_START;
                    w_sc_nxt    = '0;
                end
            end
            c_ST_START: begin
                if (w_at_dec) begin
                    if (w_vote) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_par_en_nxt   = parity_en;
                        w_par_type_nxt = odd_or_even_parity;
                        w_two_stop_nxt = two_stop;
                        w_ferr_nxt     = 1'b0;
                        w_perr_nxt     = 1'b0;
                        w_bit_nxt      = '0;
                    end
                end else if (w_at_end) begin
                    w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_at_dec) begin
                    w_shift_nxt = {w_vote, r_shift[DATA_WIDTH-1:1]};
                end else if (w_at_end) begin
                    if (r_bit_idx == c_BIT_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = r_par_en ? c_ST_PARITY : c_ST_STOP1;
                    end else begin
                        w_bit_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            c_ST_PARITY: begin
                if (w_at_dec) begin
                    w_perr_nxt = (((^r_shift) ^ w_vote) != w_par_expect);
                end else if (w_at_end) begin
                    w_state_nxt = c_ST_STOP1;
                end
            end
            c_ST_STOP1: begin
                if (w_at_dec) begin
                    if (!w_vote) w_ferr_nxt = 1'b1;
                    if (!r_two_stop) begin
                        w_push      = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (w_at_end) begin
                    w_state_nxt = c_ST_STOP2;
                end
            end
            c_ST_STOP2: begin
                if (w_at_dec) begin
                    if (!w_vote) w_ferr_nxt = 1'b1;
                    w_push      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    uart_sync_fifo #(
        .WIDTH (c_FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (rd_en),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    // A drop needs a full FIFO with no pop; an accepted read clears the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_push && w_full && !rd_en) begin
            r_overrun <= 1'b1;
        end else if (rd_en && !w_empty) begin
            r_overrun <= 1'b0;
        end
    end

    assign rd_data = w_head[DATA_WIDTH-1:0];
    assign rd_perr = w_head[DATA_WIDTH];
    assign rd_ferr = w_head[DATA_WIDTH+1];
    assign empty   = w_empty;
    assign full    = w_full;
    assign overrun = r_overrun;
    assign busy    = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. Frames are serialised
//               from their bit lists; a queue model of the receive FIFO
//               holds the words each frame must produce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int SYS_CLK = 50_000_000;
    localparam int BAUD    = 3_125_000;
    localparam int OVS     = 16;
    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int CW      = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          parity_en = 1'b0;
    logic          odd_or_even_parity = 1'b0;
    logic          two_stop = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_ferr;
    logic          rd_perr;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;
    logic          busy;

    typedef struct packed {
        logic          ferr;
        logic          perr;
        logic [DW-1:0] data;
    } word_t;

    word_t q[$];
    bit    m_ovr   = 1'b0;
    bit    settled = 1'b0;
    int    n_cmp   = 0;
    int    n_err   = 0;

    always #10 clk = ~clk;

    uart_rx_fifo #(
        .SYS_CLK    (SYS_CLK),
        .BAUD_RATE  (BAUD),
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OVS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx                 (rx),
        .parity_en          (parity_en),
        .odd_or_even_parity (odd_or_even_parity),
        .two_stop           (two_stop),
        .rd_en              (rd_en),
        .rd_data            (rd_data),
        .rd_ferr            (rd_ferr),
        .rd_perr            (rd_perr),
        .empty              (empty),
        .full               (full),
        .count              (count),
        .overrun            (overrun),
        .busy               (busy)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model of the receive FIFO
    function automatic void model_push(input word_t w);
        if (q.size() == DEPTH) m_ovr = 1'b1;
        else q.push_back(w);
    endfunction

    function automatic void model_pop();
        if (q.size() > 0) begin
            void'(q.pop_front());
            m_ovr = 1'b0;
        end
    endfunction

    // Per-cycle comparison whenever the line is quiet and the receiver idle
    always @(negedge clk) begin
        if (settled) begin
            chk("empty",   32'(empty),   32'(q.size() == 0));
            chk("full",    32'(full),    32'(q.size() == DEPTH));
            chk("count",   32'(count),   32'(q.size()));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("busy",    32'(busy),    32'(0));
            if (q.size() > 0) begin
                chk("rd_data", 32'(rd_data), 32'(q[0].data));
                chk("rd_ferr", 32'(rd_ferr), 32'(q[0].ferr));
                chk("rd_perr", 32'(rd_perr), 32'(q[0].perr));
            end else begin
                chk("rd_data_empty", 32'(rd_data), 32'(0));
            end
        end
    end

    // Serialise one frame, OVS clocks per bit. glitch = bit index whose
    // sample under the first vote point is inverted; abort_bits > 0 stops
    // driving after that many bits; rd_at_write pulses rd_en in the cycle
    // the receiver writes the word.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptype,
                              input bit tstop, input bit flip, input bit [1:0] stop_low,
                              input int glitch, input int abort_bits, input bit rd_at_write);
        logic [15:0] bits;
        int          nb;
        word_t       w;
        bits = '1;
        nb   = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < DW; i++) begin
            bits[nb] = d[i]; nb++;
        end
        if (pen) begin
            bits[nb] = (ptype ? (^d) : ~(^d)) ^ flip; nb++;
        end
        bits[nb] = ~stop_low[0]; nb++;
        if (tstop) begin
            bits[nb] = ~stop_low[1]; nb++;
        end
        w.data = d;
        w.perr = pen & flip;
        w.ferr = stop_low[0] | (tstop & stop_low[1]);
        settled = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (abort_bits > 0 && i == abort_bits) return;
            for (int j = 0; j < OVS; j++) begin
                @(negedge clk);
                if (i == 0 && j == 0) begin
                    parity_en          = pen;
                    odd_or_even_parity = ptype;
                    two_stop           = tstop;
                end
                rx = (i == glitch && j == 8) ? ~bits[i] : bits[i];
                if (rd_at_write) rd_en = (i * OVS + j == 12 + OVS * (nb - 1));
            end
        end
        rd_en = 1'b0;
        if (rd_at_write) model_pop();
        model_push(w);
    endtask

    task automatic settle();
        repeat (40) begin
            @(negedge clk);
            rx = 1'b1;
        end
        settled = 1'b1;
    endtask

    task automatic rd_one();
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        model_pop();
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (4) @(negedge clk);
        chk("rst_empty",   32'(empty),   32'(1));
        chk("rst_full",    32'(full),    32'(0));
        chk("rst_count",   32'(count),   32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        chk("rst_busy",    32'(busy),    32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_rd_ferr", 32'(rd_ferr), 32'(0));
        chk("rst_rd_perr", 32'(rd_perr), 32'(0));
        rst = 1'b0;
        settle();

        // 8N1 frames back to back
        send_frame(8'h0A, 0, 0, 0, 0, 2'b00, -1, 0, 0);
        send_frame(8'h39, 0, 0, 0, 0, 2'b00, -1, 0, 0);
        send_frame(8'h11, 0, 0, 0, 0, 2'b00, -1, 0, 0);
        settle();
        chk("8n1_count", 32'(count), 32'(3));
        chk("8n1_head0", 32'(rd_data), 32'h0A);
        rd_one();
        chk("8n1_head1", 32'(rd_data), 32'h39);
        rd_one();
        chk("8n1_head2", 32'(rd_data), 32'h11);
        rd_one();
        rd_one();   // read while empty is ignored

        // Parity: even correct, even flipped, odd correct
        send_frame(8'h0A, 1, 1, 0, 0, 2'b00, -1, 0, 0);
        send_frame(8'h0A, 1, 1, 0, 1, 2'b00, -1, 0, 0);
        send_frame(8'h0A, 1, 0, 0, 0, 2'b00, -1, 0, 0);
        settle();
        chk("par_even_ok", 32'(rd_perr), 32'(0));
        rd_one();
        chk("par_flip_perr", 32'(rd_perr), 32'(1));
        chk("par_flip_data", 32'(rd_data), 32'h0A);
        rd_one();
        chk("par_odd_ok", 32'(rd_perr), 32'(0));
        rd_one();

        // Stop bits: second stop low with and without two_stop
        send_frame(8'h5A, 0, 0, 1, 0, 2'b10, -1, 0, 0);
        settle();
        chk("stop2_ferr", 32'(rd_ferr), 32'(1));
        chk("stop2_data", 32'(rd_data), 32'h5A);
        rd_one();
        send_frame(8'h5A, 0, 0, 0, 0, 2'b10, -1, 0, 0);
        settle();
        chk("stop1_ferr", 32'(rd_ferr), 32'(0));
        rd_one();

        // False start: 4-sample glitch
        settled = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rx = 1'b0;
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'(1));
        settle();
        chk("glitch_empty", 32'(empty), 32'(1));

        // Single corrupted sample inside data bit 3 of 0x39
        send_frame(8'h39, 0, 0, 0, 0, 2'b00, 4, 0, 0);
        settle();
        chk("vote_data", 32'(rd_data), 32'h39);
        rd_one();

        // Overrun with depth 4
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 0, 0, 0, 0, 2'b00, -1, 0, 0);
        settle();
        chk("ovr_count",   32'(count),   32'(4));
        chk("ovr_full",    32'(full),    32'(1));
        chk("ovr_flag",    32'(overrun), 32'(1));
        chk("ovr_head",    32'(rd_data), 32'h01);
        rd_one();
        chk("ovr_clear",   32'(overrun), 32'(0));
        chk("ovr_count3",  32'(count),   32'(3));
        send_frame(8'h06, 0, 0, 0, 0, 2'b00, -1, 0, 0);
        settle();
        // Read coinciding with the write while full
        send_frame(8'h07, 0, 0, 0, 0, 2'b00, -1, 0, 1);
        settle();
        chk("rw_full_count",   32'(count),   32'(4));
        chk("rw_full_overrun", 32'(overrun), 32'(0));
        chk("rw_full_head",    32'(rd_data), 32'h03);
        repeat (4) rd_one();

        // Reset mid-DATA, then a clean frame
        send_frame(8'h5A, 0, 0, 0, 0, 2'b00, -1, 4, 0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rx  = 1'b1;
        rst = 1'b0;
        settle();
        chk("midrst_empty", 32'(empty), 32'(1));
        chk("midrst_busy",  32'(busy),  32'(0));
        send_frame(8'h11, 0, 0, 0, 0, 2'b00, -1, 0, 0);
        settle();
        chk("post_rst_data", 32'(rd_data), 32'h11);
        rd_one();

        // Randomised bursts
        for (int it = 0; it < 12; it++) begin
            int nfr;
            nfr = $urandom_range(1, 3);
            for (int k = 0; k < nfr; k++) begin
                logic [7:0] d;
                bit [1:0]   sl;
                int         g;
                d  = 8'($urandom);
                sl = 2'b00;
                if (k == nfr - 1 && $urandom_range(0, 2) == 0) sl = 2'($urandom_range(1, 3));
                g  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DW)) : -1;
                send_frame(d, 1'($urandom), 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 3) == 0), sl, g, 0, 0);
            end
            settle();
            repeat ($urandom_range(1, 3)) rd_one();
            while (q.size() > 0) rd_one();
        end

        settled = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
